// File: rtl/bank_swap_scheduler_if.sv
// Acquisition and two-bank memory bus of the bank swap scheduler.
// The master drives samples and read requests; the scheduler (slave) drives the memory strobes.
interface bank_swap_scheduler_if #(
  parameter int DEPTH_W = 4,
  parameter int DATA_W  = 7
);
  logic               arm;
  logic               sample_valid;
  logic [DATA_W-1:0]  sample_in;
  logic               rd_req;
  logic               mem_we;
  logic [DEPTH_W:0]   mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_re;
  logic [DEPTH_W:0]   mem_raddr;

  modport master (
    output arm, sample_valid, sample_in, rd_req,
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );

  modport slave (
    input  arm, sample_valid, sample_in, rd_req,
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );
endinterface

// File: rtl/bank_swap_scheduler.sv
// Ping-pong acquisition scheduler: fills one memory bank while the other is read out,
// swapping banks when the fill completes and the reader has drained its bank.
module bank_swap_scheduler #(
  parameter int DEPTH_W = 4,
  parameter int DATA_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bank_swap_scheduler_if.slave      bus,
  output logic                      write_bank,
  output logic                      read_bank,
  output logic                      sending_pending,
  output logic                      sending_started,
  output logic                      memorization_completed,
  output logic                      overrun,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILL    = 2'b01,
    ST_PENDING = 2'b10,
    ST_UNUSED  = 2'b11
  } state_t;

  localparam logic [DEPTH_W-1:0] LAST = '1;
  localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic               rd_busy_q, rd_busy_d;
  logic               write_bank_q, write_bank_d;
  logic               mem_re_q, mem_re_d;
  logic [DEPTH_W:0]   mem_raddr_q, mem_raddr_d;
  logic               mem_comp_q, mem_comp_d;
  logic               overrun_q, overrun_d;
  logic               we;
  logic               swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_busy_q    <= 1'b0;
      write_bank_q <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_raddr_q  <= '0;
      mem_comp_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_busy_q    <= rd_busy_d;
      write_bank_q <= write_bank_d;
      mem_re_q     <= mem_re_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_comp_q   <= mem_comp_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_busy_d    = rd_busy_q;
    write_bank_d = write_bank_q;
    mem_re_d     = 1'b0;
    mem_raddr_d  = mem_raddr_q;
    mem_comp_d   = 1'b0;
    overrun_d    = overrun_q;
    swap         = 1'b0;

    // Writes only happen in FILL; the reset-forced IDLE state gates mem_we asynchronously.
    we = (state_q == ST_FILL) && bus.sample_valid;

    if (bus.rd_req && rd_busy_q) begin
      mem_re_d    = 1'b1;
      mem_raddr_d = {~write_bank_q, rd_ptr_q};
      rd_ptr_d    = rd_ptr_q + ONE;
      if (rd_ptr_q == LAST) begin
        rd_busy_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (we) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (wr_ptr_q == LAST) begin
            if (rd_busy_q) begin
              state_d = ST_PENDING;
            end else begin
              swap = 1'b1;
            end
          end
        end
      end
      ST_PENDING: begin
        if (bus.sample_valid) begin
          overrun_d = 1'b1;
        end
        if (!rd_busy_q) begin
          swap    = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disarming abandons the fill in progress; the read engine keeps draining its bank.
    if (!bus.arm) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      swap     = 1'b0;
    end

    if (swap) begin
      write_bank_d = ~write_bank_q;
      wr_ptr_d     = '0;
      rd_busy_d    = 1'b1;
      rd_ptr_d     = '0;
      mem_comp_d   = 1'b1;
    end
  end

  assign bus.mem_we              = we;
  assign bus.mem_waddr           = {write_bank_q, wr_ptr_q};
  assign bus.mem_wdata           = bus.sample_in;
  assign bus.mem_re              = mem_re_q;
  assign bus.mem_raddr           = mem_raddr_q;
  assign write_bank              = write_bank_q;
  assign read_bank               = ~write_bank_q;
  assign sending_pending         = (state_q == ST_PENDING);
  assign sending_started         = rd_busy_q;
  assign memorization_completed  = mem_comp_q;
  assign overrun                 = overrun_q;
  assign state                   = state_q;

endmodule

// File: tb/tb_bank_swap_scheduler.sv
// Directed bench for bank_swap_scheduler with 4-word banks; expectations hand-derived.
module tb_bank_swap_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       write_bank, read_bank, sending_pending, sending_started;
  logic       memorization_completed, overrun;
  logic [1:0] state;
  int         total  = 0;
  int         passed = 0;

  bank_swap_scheduler_if #(.DEPTH_W(2), .DATA_W(7)) bus ();

  bank_swap_scheduler #(.DEPTH_W(2), .DATA_W(7)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus                    (bus),
    .write_bank             (write_bank),
    .read_bank              (read_bank),
    .sending_pending        (sending_pending),
    .sending_started        (sending_started),
    .memorization_completed (memorization_completed),
    .overrun                (overrun),
    .state                  (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.arm = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    bus.rd_req = 1'b0;
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_wbank", 32'(write_bank), 0);
    chk("rst_rbank", 32'(read_bank), 1);
    chk("rst_re", 32'(bus.mem_re), 0);
    chk("rst_raddr", 32'(bus.mem_raddr), 0);
    chk("rst_started", 32'(sending_started), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 0);

    // First fill of bank 0
    bus.arm = 1'b1;
    tick();
    chk("arm_fill", 32'(state), 1);
    for (int i = 0; i < 4; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in = 7'(8'h11 + i);
      #1;
      chk("f0_we", 32'(bus.mem_we), 1);
      chk("f0_waddr", 32'(bus.mem_waddr), 32'(i));
      chk("f0_wdata", 32'(bus.mem_wdata), 32'(8'h11 + i));
      tick();
    end
    bus.sample_valid = 1'b0;
    chk("f0_memcomp", 32'(memorization_completed), 1);
    chk("f0_wbank", 32'(write_bank), 1);
    chk("f0_rbank", 32'(read_bank), 0);
    chk("f0_started", 32'(sending_started), 1);
    chk("f0_state", 32'(state), 1);
    tick();
    chk("f0_pulse_end", 32'(memorization_completed), 0);

    // Drain bank 0 with spaced requests
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      chk("r0_re", 32'(bus.mem_re), 1);
      chk("r0_raddr", 32'(bus.mem_raddr), 32'(i));
      tick();
      chk("r0_re_off", 32'(bus.mem_re), 0);
    end
    chk("r0_done", 32'(sending_started), 0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("ign_rd", 32'(bus.mem_re), 0);

    // Fill bank 1 with reader idle: immediate swap
    for (int i = 0; i < 4; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in = 7'(8'h21 + i);
      #1;
      chk("f1_waddr", 32'(bus.mem_waddr), 32'(4 + i));
      tick();
    end
    bus.sample_valid = 1'b0;
    chk("f1_memcomp", 32'(memorization_completed), 1);
    chk("f1_wbank", 32'(write_bank), 0);
    chk("f1_started", 32'(sending_started), 1);

    // Fill bank 0 while bank 1 is still unread: pending
    for (int i = 0; i < 4; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in = 7'(8'h31 + i);
      #1;
      chk("f2_waddr", 32'(bus.mem_waddr), 32'(i));
      tick();
    end
    bus.sample_valid = 1'b0;
    chk("pend_state", 32'(state), 2);
    chk("pend_flag", 32'(sending_pending), 1);
    chk("pend_wbank", 32'(write_bank), 0);
    chk("pend_memcomp", 32'(memorization_completed), 0);
    bus.sample_valid = 1'b1;
    bus.sample_in = 7'h35;
    #1;
    chk("ovr_we", 32'(bus.mem_we), 0);
    tick();
    bus.sample_valid = 1'b0;
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_state", 32'(state), 2);

    // Drain bank 1; swap lands on the edge after the last read
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      chk("r1_re", 32'(bus.mem_re), 1);
      chk("r1_raddr", 32'(bus.mem_raddr), 32'(4 + i));
      chk("r1_state", 32'(state), 2);
      tick();
    end
    chk("sw_state", 32'(state), 1);
    chk("sw_wbank", 32'(write_bank), 1);
    chk("sw_memcomp", 32'(memorization_completed), 1);
    chk("sw_pending", 32'(sending_pending), 0);
    chk("sw_started", 32'(sending_started), 1);
    chk("sw_overrun", 32'(overrun), 1);
    bus.sample_valid = 1'b1;
    bus.sample_in = 7'h41;
    #1;
    chk("sw_we", 32'(bus.mem_we), 1);
    chk("sw_waddr", 32'(bus.mem_waddr), 4);
    tick();
    bus.sample_valid = 1'b0;

    // Last write and last read on the same edge
    bus.rd_req = 1'b1;
    tick();
    tick();
    tick();
    bus.rd_req = 1'b0;
    chk("b2b_raddr", 32'(bus.mem_raddr), 2);
    bus.sample_valid = 1'b1;
    tick();
    tick();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.sample_valid = 1'b0;
    chk("coin_re", 32'(bus.mem_re), 1);
    chk("coin_raddr", 32'(bus.mem_raddr), 3);
    chk("coin_state", 32'(state), 2);
    chk("coin_started", 32'(sending_started), 0);
    tick();
    chk("coin_swap", 32'(state), 1);
    chk("coin_wbank", 32'(write_bank), 0);
    chk("coin_memcomp", 32'(memorization_completed), 1);

    // Asynchronous reset in the middle of reading bank 1
    bus.rd_req = 1'b1;
    tick();
    tick();
    bus.sample_valid = 1'b1;
    #1;
    chk("mid_re", 32'(bus.mem_re), 1);
    chk("mid_raddr", 32'(bus.mem_raddr), 5);
    chk("mid_we", 32'(bus.mem_we), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_we", 32'(bus.mem_we), 0);
    chk("ar_re", 32'(bus.mem_re), 0);
    chk("ar_raddr", 32'(bus.mem_raddr), 0);
    chk("ar_waddr", 32'(bus.mem_waddr), 0);
    chk("ar_wbank", 32'(write_bank), 0);
    chk("ar_rbank", 32'(read_bank), 1);
    chk("ar_started", 32'(sending_started), 0);
    chk("ar_pending", 32'(sending_pending), 0);
    chk("ar_memcomp", 32'(memorization_completed), 0);
    chk("ar_overrun", 32'(overrun), 0);
    bus.rd_req = 1'b0;
    bus.sample_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_state", 32'(state), 0);
    tick();
    chk("rel_fill", 32'(state), 1);
    chk("rel_memcomp", 32'(memorization_completed), 0);
    chk("rel_wbank", 32'(write_bank), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
